// File: rtl/motor_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_sequencer_if
// Description : Command channel between a motion controller and the motor
//               command sequencer. Valid/ready handshake carrying a duty
//               magnitude and a direction.
//               master : drives cmd_valid, cmd_duty, cmd_dir; sees cmd_ready
//               slave  : sees cmd_valid, cmd_duty, cmd_dir; drives cmd_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_cmd_sequencer_if #(
    parameter int DUTY_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DUTY_WIDTH-1:0] cmd_duty;
    logic                  cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_duty,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        input  cmd_dir,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_sequencer
// Description : Turns duty/direction commands into a rate-limited drive for a
//               BLDC driver. Reversals brake to zero, coast for a dwell time,
//               then ramp back up. Includes a command watchdog and a driver
//               fault trap.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               cmd          - command channel (slave side)
//               drv_fault    - fault flag from the BLDC driver
//               clear_fault  - one-cycle request to leave FAULT
//               drv_en       - driver enable
//               drv_duty     - duty to the driver
//               drv_dir      - direction to commutation logic
//               wd_timeout   - sticky watchdog-expired flag
//               fault_count  - saturating count of FAULT entries
//               busy         - state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module motor_cmd_sequencer #(
    parameter int          DUTY_WIDTH      = 10,
    parameter int unsigned MAX_DUTY        = 'h3FF,
    parameter int unsigned RAMP_STEP       = 8,
    parameter int unsigned RAMP_DIV        = 32,
    parameter int unsigned REVERSE_DWELL   = 1024,
    parameter int unsigned WATCHDOG_CYCLES = 65535
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    motor_cmd_sequencer_if.slave       cmd,
    input  wire logic                  drv_fault,
    input  wire logic                  clear_fault,
    output logic                       drv_en,
    output logic [DUTY_WIDTH-1:0]      drv_duty,
    output logic                       drv_dir,
    output logic                       wd_timeout,
    output logic [3:0]                 fault_count,
    output logic                       busy
);

    localparam int c_pw   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int c_dw_w = (REVERSE_DWELL > 1) ? $clog2(REVERSE_DWELL) : 1;
    localparam int c_wd_w = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [DUTY_WIDTH-1:0] c_max_duty   = DUTY_WIDTH'(MAX_DUTY);
    localparam logic [DUTY_WIDTH:0]   c_step       = (DUTY_WIDTH+1)'(RAMP_STEP);
    localparam logic [c_pw-1:0]       c_presc_last = c_pw'(RAMP_DIV - 1);
    localparam logic [c_dw_w-1:0]     c_dwell_last = c_dw_w'(REVERSE_DWELL - 1);
    localparam logic [c_wd_w-1:0]     c_wd_limit   = c_wd_w'(WATCHDOG_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_BRAKE = 3'd3,
        S_DWELL = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                  state_q,       state_d;
    logic [c_pw-1:0]         presc_q,       presc_d;
    logic [c_dw_w-1:0]       dwell_q,       dwell_d;
    logic [c_wd_w-1:0]       wd_q,          wd_d;
    logic [DUTY_WIDTH-1:0]   target_duty_q, target_duty_d;
    logic                    target_dir_q,  target_dir_d;
    logic                    drv_en_q,      drv_en_d;
    logic [DUTY_WIDTH-1:0]   drv_duty_q,    drv_duty_d;
    logic                    drv_dir_q,     drv_dir_d;
    logic                    wd_timeout_q,  wd_timeout_d;
    logic [3:0]              fault_count_q, fault_count_d;

    logic                    w_accept;
    logic                    w_tick;
    logic                    w_active;
    logic                    w_fault;
    logic                    w_wd_expire;
    logic [DUTY_WIDTH-1:0]   w_cmd_duty;
    logic [DUTY_WIDTH-1:0]   w_goal;
    logic                    w_up;
    logic [DUTY_WIDTH-1:0]   w_dist;
    logic [DUTY_WIDTH-1:0]   w_mag;
    logic [DUTY_WIDTH-1:0]   w_stepped;

    assign cmd.cmd_ready = (state_q != S_FAULT);
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_tick        = (presc_q == c_presc_last);
    // Supervised states: fault trapping and the watchdog only apply here.
    assign w_active      = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign w_fault       = drv_fault && w_active;
    assign w_wd_expire   = (wd_q == c_wd_limit) && w_active;
    assign w_cmd_duty    = (cmd.cmd_duty > c_max_duty) ? c_max_duty : cmd.cmd_duty;

    // One ramp step toward the goal; the magnitude is capped by the remaining
    // distance so the duty lands exactly on the goal and never wraps.
    assign w_goal    = (state_q == S_BRAKE) ? '0 : target_duty_q;
    assign w_up      = (w_goal > drv_duty_q);
    assign w_dist    = w_up ? (w_goal - drv_duty_q) : (drv_duty_q - w_goal);
    assign w_mag     = ({1'b0, w_dist} > c_step) ? c_step[DUTY_WIDTH-1:0] : w_dist;
    assign w_stepped = w_up ? (drv_duty_q + w_mag) : (drv_duty_q - w_mag);

    always_comb begin
        state_d       = state_q;
        presc_d       = w_tick ? '0 : (presc_q + c_pw'(1));
        dwell_d       = '0;
        wd_d          = wd_q;
        target_duty_d = target_duty_q;
        target_dir_d  = target_dir_q;
        drv_en_d      = drv_en_q;
        drv_duty_d    = drv_duty_q;
        drv_dir_d     = drv_dir_q;
        wd_timeout_d  = wd_timeout_q;
        fault_count_d = fault_count_q;

        if (w_accept || !w_active) begin
            wd_d = '0;
        end else if (wd_q != c_wd_limit) begin
            wd_d = wd_q + c_wd_w'(1);
        end

        // A fresh command wins over a simultaneous watchdog expiry.
        if (w_accept) begin
            target_duty_d = w_cmd_duty;
            target_dir_d  = cmd.cmd_dir;
            wd_timeout_d  = 1'b0;
        end else if (w_wd_expire) begin
            target_duty_d = '0;
            wd_timeout_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                drv_en_d   = 1'b0;
                drv_duty_d = '0;
                if (target_duty_q != '0) begin
                    drv_dir_d = target_dir_q;
                    drv_en_d  = 1'b1;
                    state_d   = S_RAMP;
                end
            end
            S_RAMP: begin
                if ((target_duty_q == '0) && (drv_duty_q == '0)) begin
                    drv_en_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (target_dir_q != drv_dir_q) begin
                    state_d = S_BRAKE;
                end else if (drv_duty_q == target_duty_q) begin
                    state_d = S_HOLD;
                end else if (w_tick) begin
                    drv_duty_d = w_stepped;
                end
            end
            S_HOLD: begin
                if (target_dir_q != drv_dir_q) begin
                    state_d = S_BRAKE;
                end else if (target_duty_q != drv_duty_q) begin
                    state_d = S_RAMP;
                end
            end
            S_BRAKE: begin
                if (drv_duty_q == '0) begin
                    drv_en_d = 1'b0;
                    state_d  = S_DWELL;
                end else if (w_tick) begin
                    drv_duty_d = w_stepped;
                end
            end
            S_DWELL: begin
                drv_en_d = 1'b0;
                // Direction flips only here and in IDLE, both with the bridge
                // disabled and the duty at zero.
                if (dwell_q == c_dwell_last) begin
                    drv_dir_d = target_dir_q;
                    if (target_duty_q != '0) begin
                        drv_en_d = 1'b1;
                        state_d  = S_RAMP;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + c_dw_w'(1);
                end
            end
            S_FAULT: begin
                drv_en_d   = 1'b0;
                drv_duty_d = '0;
                if (clear_fault && !drv_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A driver fault overrides everything else decided this cycle.
        if (w_fault) begin
            state_d       = S_FAULT;
            drv_en_d      = 1'b0;
            drv_duty_d    = '0;
            target_duty_d = '0;
            dwell_d       = '0;
            if (fault_count_q != 4'hF) begin
                fault_count_d = fault_count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            dwell_q       <= '0;
            wd_q          <= '0;
            target_duty_q <= '0;
            target_dir_q  <= 1'b0;
            drv_en_q      <= 1'b0;
            drv_duty_q    <= '0;
            drv_dir_q     <= 1'b0;
            wd_timeout_q  <= 1'b0;
            fault_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            dwell_q       <= dwell_d;
            wd_q          <= wd_d;
            target_duty_q <= target_duty_d;
            target_dir_q  <= target_dir_d;
            drv_en_q      <= drv_en_d;
            drv_duty_q    <= drv_duty_d;
            drv_dir_q     <= drv_dir_d;
            wd_timeout_q  <= wd_timeout_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign drv_en      = drv_en_q;
    assign drv_duty    = drv_duty_q;
    assign drv_dir     = drv_dir_q;
    assign wd_timeout  = wd_timeout_q;
    assign fault_count = fault_count_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/motor_cmd_sequencer.md
MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 Parameter DUTY_WIDTH, default 10: width of all duty-cycle values.
REQ-002 Parameter MAX_DUTY, default 'h3FF: largest duty driven to the BLDC driver.
REQ-003 Parameter RAMP_STEP, default 8: largest drv_duty change per ramp tick.
REQ-004 Parameter RAMP_DIV, default 32: clock cycles per ramp tick.
REQ-005 Parameter REVERSE_DWELL, default 1024: coast cycles required before a direction change.
REQ-006 Parameter WATCHDOG_CYCLES, default 65535: maximum cycles without an accepted command while active.
REQ-007 clk  input  1  the single clock; all logic is on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 cmd_valid  input  1  a command is offered.
REQ-010 cmd_ready  output  1  the sequencer can accept a command.
REQ-011 cmd_duty  input  DUTY_WIDTH  requested duty magnitude.
REQ-012 cmd_dir  input  1  requested direction.
REQ-013 drv_fault  input  1  fault output of the BLDC driver.
REQ-014 clear_fault  input  1  single-cycle request to leave FAULT.
REQ-015 drv_en  output  1  enable to the BLDC driver.
REQ-016 drv_duty  output  DUTY_WIDTH  duty to the BLDC driver.
REQ-017 drv_dir  output  1  direction to the commutation logic.
REQ-018 wd_timeout  output  1  sticky watchdog-expired flag.
REQ-019 fault_count  output  4  saturating count of FAULT entries.
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 States SHALL be IDLE, RAMP, HOLD, BRAKE, DWELL and FAULT.
REQ-022 cmd_ready SHALL be high in every state except FAULT; a command is accepted on any cycle with cmd_valid and cmd_ready both high.
REQ-023 An accepted command SHALL latch target_dir=cmd_dir and target_duty=min(cmd_duty, MAX_DUTY); this takes effect on the next cycle.
REQ-024 A free-running prescaler SHALL wrap at RAMP_DIV-1; the wrap cycle is the ramp tick.
REQ-025 On each ramp tick in RAMP or BRAKE, drv_duty SHALL move toward its goal by min(RAMP_STEP, |goal-drv_duty|), never overshooting and never wrapping.
REQ-026 IDLE: drv_en=0 and drv_duty=0. A latched target_duty>0 SHALL set drv_dir=target_dir and drv_en=1, then go to RAMP.
REQ-027 RAMP: goal=target_duty. Go to HOLD when drv_duty==target_duty and target_duty>0. Go to IDLE with drv_en=0 when drv_duty==0 and target_duty==0.
REQ-028 HOLD: drv_duty is constant. A new target with the same direction SHALL go to RAMP. A target with target_dir!=drv_dir SHALL go to BRAKE.
REQ-029 A direction mismatch in RAMP SHALL also go to BRAKE.
REQ-030 BRAKE: goal=0. At drv_duty==0, drv_en SHALL drop to 0 and the state goes to DWELL.
REQ-031 DWELL: drv_en=0. After REVERSE_DWELL cycles, drv_dir SHALL become target_dir. The next state is RAMP with drv_en=1 if target_duty>0, otherwise IDLE.
REQ-032 drv_dir SHALL change only while drv_duty==0 and drv_en==0.
REQ-033 Watchdog: the counter clears on every accepted command and in IDLE, and counts in all other non-FAULT states.
REQ-034 When the watchdog count reaches WATCHDOG_CYCLES, target_duty SHALL be forced to 0 and wd_timeout set. wd_timeout clears on the next accepted command.
REQ-035 drv_fault high in any state other than IDLE or FAULT SHALL enter FAULT on the next cycle, with drv_en=0 and drv_duty=0 in that same cycle, target_duty cleared and fault_count incremented (saturating at 15).
REQ-036 FAULT SHALL exit to IDLE only when clear_fault is high and drv_fault is low.
REQ-037 Simultaneous events: fault beats command, and an accepted command beats watchdog expiry.

Reset
REQ-038 While rst_n is low, the following SHALL hold immediately, independent of clk: state=IDLE, drv_en=0, drv_duty=0, drv_dir=0, cmd_ready=1, wd_timeout=0, fault_count=0, busy=0, and the prescaler, watchdog and dwell counters are 0.
REQ-039 Reset asserted mid-ramp SHALL drop drv_en within the same cycle, with no further duty steps.

Verification
REQ-040 Command duty=100, dir=0 from IDLE -> drv_en=1; drv_duty goes 8, 16, … 96, 100 on successive ticks, 32 cycles apart; then HOLD.
REQ-041 In HOLD at 100, dir=0, command duty=40, dir=1 -> drv_duty ramps down to 0, drv_en=0, then 1024 dwell cycles, drv_dir=1, ramp up to 40.
REQ-042 drv_fault pulse in RAMP -> drv_en=0 and drv_duty=0 on the next cycle; cmd_ready=0; fault_count=1; clear_fault returns to IDLE.
REQ-043 No command for 65535 cycles at duty 200 -> wd_timeout=1, ramp to 0, IDLE; a new command clears wd_timeout.
REQ-044 cmd_duty='h3FF+ (all ones) with MAX_DUTY='h300 -> the ramp stops at 'h300.
REQ-045 rst_n low during BRAKE -> all outputs take their reset values asynchronously; after release, the block is in IDLE.
